// File: rtl/nibble_serial_adder_ctrl.sv
// Serial adder controller: adds two WIDTH-bit operands one nibble per clock through a
// shared 4-bit slice. Define NSA_SUB_EN to add the sub port and two's-complement subtract.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // RUN   | one nibble added per edge, busy high
    // DONE  | result presented, held until out_ready
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice;

    assign base  = {idx, 2'b00};
    assign a_nib = op_a[base +: 4];
    assign b_nib = op_b[base +: 4];
    assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_a <= a;
`ifdef NSA_SUB_EN
                        // Subtract is A + ~B + 1, so the inverted operand is stored.
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
`else
                        op_b  <= b;
                        carry <= c_in;
`endif
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[base +: 4] <= slice[3:0];
                    carry          <= slice[4];
                    if (idx == LAST_IDX) begin
                        c_out <= slice[4];
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed cases plus random ops against an
// arithmetic reference model; subtract cases only when NSA_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef NSA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef NSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        a    = WIDTH'($urandom);
        b    = WIDTH'($urandom);
        c_in = 1'($urandom);
`ifdef NSA_SUB_EN
        sub  = 1'($urandom);
`endif
    endtask

    // One full transaction; the expected result comes from plain integer arithmetic.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input logic sb, input int hold);
        logic [WIDTH:0] full;
        int             waitc;
        if (sb)
            full = {1'b0, av} - {1'b0, bv} + (WIDTH+1)'(1 << WIDTH);
        else
            full = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, ci};
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk("in_ready_idle", in_ready, 1);
        a = av; b = bv; c_in = ci;
`ifdef NSA_SUB_EN
        sub = sb;
`endif
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= NIB; k++) begin
            chk("busy_run", busy, 1);
            chk("valid_early", out_valid, 0);
            chk("in_ready_run", in_ready, 0);
            scramble_inputs();
            @(posedge clk); #1;
        end
        chk("busy_done", busy, 0);
        chk("out_valid", out_valid, 1);
        chk("sum", sum, full[WIDTH-1:0]);
        chk("c_out", c_out, full[WIDTH]);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum", sum, full[WIDTH-1:0]);
            chk("hold_c_out", c_out, full[WIDTH]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("sum_kept", sum, full[WIDTH-1:0]);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rsb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
`ifdef NSA_SUB_EN
        sub = 1'b0;
`endif
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // out_ready with nothing pending must not disturb the idle controller
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_ready", out_valid, 0);

        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 3);

        // Reset after two RUN edges drops the operation
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_c_out", c_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < NIB + 2; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", out_valid, 0);
        end
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0);

`ifdef NSA_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        chk("sub_neg_sum", sum, 16'hFFFE);
        chk("sub_neg_c", c_out, 0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        chk("sub_pos_sum", sum, 16'h0002);
        chk("sub_pos_c", c_out, 1);
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (i % 17 == 0) ra = '1;
            if (i % 23 == 0) rb = '1;
`ifdef NSA_SUB_EN
            rsb = 1'($urandom);
`else
            rsb = 1'b0;
`endif
            do_op(ra, rb, 1'($urandom), rsb, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
